// File: rtl/serial_bank_mapper_pkg.sv
// Shared encodings for the serial-load bank mapper.
package mapper_pkg;

  // Number of accepted serial writes that make up one register load
  localparam int unsigned SERIAL_LEN = 5;

  // Control register contents after reset: PRG mode 11, one-screen low, CHR 8 KB
  localparam logic [4:0] CTRL_RESET = 5'b01100;

  // Register selected by CPU_A14:CPU_A13 on the committing write
  typedef enum logic [1:0] {
    SEL_CTRL = 2'b00,
    SEL_CHR0 = 2'b01,
    SEL_CHR1 = 2'b10,
    SEL_PRG  = 2'b11
  } reg_sel_e;

  // PRG banking mode, CTRL[3:2]
  typedef enum logic [1:0] {
    PRG_32K_A  = 2'b00,
    PRG_32K_B  = 2'b01,
    PRG_FIX_LO = 2'b10,
    PRG_FIX_HI = 2'b11
  } prg_mode_e;

  // Nametable mirroring, CTRL[1:0]
  typedef enum logic [1:0] {
    MIR_ONE_LO = 2'b00,
    MIR_ONE_HI = 2'b01,
    MIR_VERT   = 2'b10,
    MIR_HORIZ  = 2'b11
  } mirror_e;

endpackage

// File: rtl/serial_bank_mapper_serial_load_port.sv
// Serial write port: write detect, consecutive-write filter, 5-bit shifter.
// The commit and reset strobes are combinational so the bank registers
// load on the same M2 falling edge as the fifth accepted write.
module serial_load_port
  import mapper_pkg::*;
(
  input  logic       i_m2,
  input  logic       i_rst_n,
  input  logic       i_romsel_n,
  input  logic       i_rw_n,
  input  logic       i_a14,
  input  logic       i_a13,
  input  logic       i_d0,
  input  logic       i_d7,
  output logic       o_commit,
  output logic [4:0] o_data,
  output reg_sel_e   o_sel,
  output logic       o_d7_reset
);

  logic [4:0] r_shift;
  logic [2:0] r_count;
  logic       r_prev_wr;

  logic w_wr;
  logic w_accept;
  logic w_last;

  assign w_wr     = !i_romsel_n && !i_rw_n;
  assign w_accept = w_wr && !r_prev_wr;
  assign w_last   = (r_count == 3'(SERIAL_LEN - 1));

  // Shift register, write counter and previous-cycle write flag
  always_ff @(negedge i_m2 or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_shift   <= '0;
      r_count   <= '0;
      r_prev_wr <= 1'b0;
    end else begin
      r_prev_wr <= w_wr;
      if (w_accept) begin
        if (i_d7 || w_last) begin
          r_shift <= '0;
          r_count <= '0;
        end else begin
          r_shift <= {i_d0, r_shift[4:1]};
          r_count <= r_count + 3'd1;
        end
      end
    end
  end

  assign o_commit   = w_accept && !i_d7 && w_last;
  assign o_data     = {i_d0, r_shift[4:1]};
  assign o_sel      = reg_sel_e'({i_a14, i_a13});
  assign o_d7_reset = w_accept && i_d7;

endmodule

// File: rtl/serial_bank_mapper.sv
// MMC1B-class bank mapper: bank registers and PRG/CHR/WRAM/CIRAM decode.
module serial_bank_mapper
  import mapper_pkg::*;
#(
  parameter int unsigned PRG_BANK_BITS  = 5,
  parameter int unsigned CHR_BANK_BITS  = 5,
  parameter int unsigned WRAM_BANK_BITS = 2,
  parameter int unsigned OUTER_PRG_EN   = 1
) (
  input  logic                      CPU_M2,
  input  logic                      nRESET,
  input  logic                      CPU_A14,
  input  logic                      CPU_A13,
  input  logic                      nCPU_ROMSEL,
  input  logic                      nCPU_RW,
  input  logic                      CPU_D0,
  input  logic                      CPU_D7,
  input  logic                      PPU_A12,
  input  logic                      PPU_A11,
  input  logic                      PPU_A10,
  output logic [PRG_BANK_BITS-1:0]  PRG_A,
  output logic [CHR_BANK_BITS-1:0]  CHR_A,
  output logic [((WRAM_BANK_BITS > 0) ? WRAM_BANK_BITS : 1)-1:0] WRAM_A,
  output logic                      nPRG_CE,
  output logic                      nWRAM_CE,
  output logic                      CIRAM_A10
);

  logic [4:0] r_ctrl;
  logic [4:0] r_chr0;
  logic [4:0] r_chr1;
  logic [4:0] r_prg;

  logic       w_commit;
  logic [4:0] w_data;
  reg_sel_e   w_sel;
  logic       w_d7_reset;
  logic [4:0] w_prg_full;
  logic [4:0] w_chr_full;

  serial_load_port u_port (
    .i_m2       (CPU_M2),
    .i_rst_n    (nRESET),
    .i_romsel_n (nCPU_ROMSEL),
    .i_rw_n     (nCPU_RW),
    .i_a14      (CPU_A14),
    .i_a13      (CPU_A13),
    .i_d0       (CPU_D0),
    .i_d7       (CPU_D7),
    .o_commit   (w_commit),
    .o_data     (w_data),
    .o_sel      (w_sel),
    .o_d7_reset (w_d7_reset)
  );

  // Bank registers, loaded on the M2 falling edge of a committing write
  always_ff @(negedge CPU_M2 or negedge nRESET) begin
    if (!nRESET) begin
      r_ctrl <= CTRL_RESET;
      r_chr0 <= '0;
      r_chr1 <= '0;
      r_prg  <= '0;
    end else if (w_d7_reset) begin
      r_ctrl[3:2] <= 2'b11;
    end else if (w_commit) begin
      unique case (w_sel)
        SEL_CTRL: r_ctrl <= w_data;
        SEL_CHR0: r_chr0 <= w_data;
        SEL_CHR1: r_chr1 <= w_data;
        SEL_PRG:  r_prg  <= w_data;
      endcase
    end
  end

  // Bank and nametable multiplexers from the current register state
  always_comb begin
    w_prg_full = '0;
    w_chr_full = '0;
    CIRAM_A10  = 1'b0;

    unique case (prg_mode_e'(r_ctrl[3:2]))
      PRG_32K_A, PRG_32K_B: w_prg_full[3:0] = {r_prg[3:1], CPU_A14};
      PRG_FIX_LO:           w_prg_full[3:0] = CPU_A14 ? r_prg[3:0] : 4'h0;
      PRG_FIX_HI:           w_prg_full[3:0] = CPU_A14 ? 4'hF : r_prg[3:0];
    endcase
    w_prg_full[4] = (OUTER_PRG_EN != 0) ? r_chr0[4] : 1'b0;

    if (r_ctrl[4]) w_chr_full = PPU_A12 ? r_chr1 : r_chr0;
    else           w_chr_full = {r_chr0[4:1], PPU_A12};

    unique case (mirror_e'(r_ctrl[1:0]))
      MIR_ONE_LO: CIRAM_A10 = 1'b0;
      MIR_ONE_HI: CIRAM_A10 = 1'b1;
      MIR_VERT:   CIRAM_A10 = PPU_A10;
      MIR_HORIZ:  CIRAM_A10 = PPU_A11;
    endcase
  end

  assign PRG_A = w_prg_full[PRG_BANK_BITS-1:0];
  assign CHR_A = w_chr_full[CHR_BANK_BITS-1:0];

  generate
    if (WRAM_BANK_BITS == 0) begin : g_no_wram_bank
      assign WRAM_A = '0;
    end else begin : g_wram_bank
      assign WRAM_A = r_chr0[2 +: WRAM_BANK_BITS];
    end
  endgenerate

  assign nWRAM_CE = !(CPU_M2 && nCPU_ROMSEL && CPU_A14 && CPU_A13 && !r_prg[4]);
  assign nPRG_CE  = nCPU_ROMSEL || !nCPU_RW;

endmodule

// File: doc/serial_bank_mapper.md
# serial_bank_mapper

Parametrised second-generation serial-load bank mapper for the Famicom cartridge (MMC1B/SxROM class). It decodes CPU writes to $8000–$FFFF through a 5-write serial port into control, CHR and PRG bank registers. It drives PRG, CHR, WRAM and CIRAM address lines. Over the first-generation block it adds a consecutive-write filter, WRAM bank and disable bits, a SUROM-style outer PRG bank, and width parameters.

## Interface
Parameters:
- PRG_BANK_BITS, 5: PRG 16 KB bank output bits (legal 4..5); bit 4 exists only when 5.
- CHR_BANK_BITS, 5: CHR 4 KB bank output bits (legal 3..5); upper register bits are truncated.
- WRAM_BANK_BITS, 2: WRAM 8 KB bank bits (legal 0..2).
- OUTER_PRG_EN, 1: 1 = CHR0[4] drives PRG_A[4] (512 KB PRG).

Ports:
- CPU_M2 in 1: the single clock; all state updates on its falling edge.
- nRESET in 1: asynchronous, active-low reset.
- CPU_A14, CPU_A13 in 1 each: register select and WRAM decode.
- nCPU_ROMSEL in 1: active-low $8000–$FFFF select.
- nCPU_RW in 1: low = CPU write.
- CPU_D0, CPU_D7 in 1 each: serial data bit and reset bit.
- PPU_A12, PPU_A11, PPU_A10 in 1 each: PPU address.
- PRG_A out PRG_BANK_BITS: PRG address bits A14 and up.
- CHR_A out CHR_BANK_BITS: CHR address bits A12 and up.
- WRAM_A out max(WRAM_BANK_BITS,1): WRAM address bits A13 and up; 0 when WRAM_BANK_BITS=0.
- nPRG_CE out 1: PRG ROM enable, active-low.
- nWRAM_CE out 1: WRAM enable, active-low.
- CIRAM_A10 out 1: nametable select.

## Operation
- Write event: at the falling edge of CPU_M2, nCPU_ROMSEL=0 and nCPU_RW=0.
- Consecutive-write filter: the `prev_wr` flag records a write event in the prior M2 cycle. A write event with `prev_wr=1` is ignored entirely, including D7. `prev_wr` updates every cycle.
- Accepted write, D7=1: clear the shift register and count, and set CTRL[3:2]=2'b11. Other register bits are unchanged.
- Accepted write, D7=0: shift D0 into shift[4], shifting right, and increment the 3-bit count.
  - On the 5th accepted write, commit {D0, shift[4:1]} to the register selected by that write's A14:A13: 00 = CTRL, 01 = CHR0, 10 = CHR1, 11 = PRG.
  - Then clear the shift register and count.
- Mirroring (CTRL[1:0]): 00 → CIRAM_A10 = 0, 01 → 1, 10 → PPU_A10, 11 → PPU_A11.
- PRG mode (CTRL[3:2]): 0x → 32 KB, lower 4 bits = {PRG[3:1], CPU_A14}.
  - 10 → A14=0 gives bank 0, A14=1 gives PRG[3:0].
  - 11 → A14=0 gives PRG[3:0], A14=1 gives 4'hF.
  - PRG_A[4] = OUTER_PRG_EN ? CHR0[4] : 0, in every mode.
- CHR mode (CTRL[4]): 0 → {CHR0[4:1], PPU_A12}; 1 → PPU_A12 ? CHR1 : CHR0. The result is truncated to CHR_BANK_BITS.
- WRAM_A = CHR0[3:2], low WRAM_BANK_BITS bits.
- nWRAM_CE = !(CPU_M2 & nCPU_ROMSEL & CPU_A14 & CPU_A13 & !PRG[4]).
- nPRG_CE = nCPU_ROMSEL | !nCPU_RW.

## Timing
- Reset values (async, immediate): shift=0, count=0, prev_wr=0, CTRL=5'b01100, CHR0=CHR1=PRG=0.
- Outputs after reset: CIRAM_A10=0; PRG_A = 0 at A14=0 and 5'b01111 at A14=1; CHR_A = {0000, PPU_A12}; WRAM_A=0.
- Register commit is visible on outputs immediately after the M2 falling edge of the 5th write. All output paths from registers to outputs are combinational with zero latency.
- Address-only paths (PPU_A*, CPU_A14, nCPU_ROMSEL) are purely combinational.
- Reset asserted mid-sequence discards any partial shift. The next write after release counts as write 1.
- A D7=1 write during a sequence aborts it. The count restarts at 0.
- A filtered write neither counts nor clears the sequence.

## Structure
- Package `mapper_pkg`: register-select encodings, CTRL_RESET = 5'b01100, PRG-mode and mirroring enums, and the serial length constant 5.
- Sub-module `serial_load_port`: write detect, consecutive-write filter, shift register and counter. It emits a one-cycle commit strobe with 5-bit data and 2-bit select.
- Top level: bank registers and output multiplexers.

## Test plan
- Reset, no writes → CIRAM_A10=0; PRG_A: A14=0 → 0, A14=1 → 5'b01111; CHR_A = {0000, PPU_A12}.
- 5 writes to $8000 with D0 = 0,1,0,1,1 (CTRL=5'b11010) → CHR 4 KB mode, PRG mode 10, CIRAM_A10 follows PPU_A10.
- Write D7=1 after 3 serial writes, then 5 writes of value 5'b00101 to $E000 → PRG=5; with A14=0, PRG_A=5 (mode 11).
- Two back-to-back write cycles (RMW pattern) inside a sequence → the second is ignored; 6 total cycles are needed to commit.
- CHR0=5'b11000 with OUTER_PRG_EN=1 and WRAM_BANK_BITS=2 → PRG_A[4]=1 in both halves, WRAM_A=2'b10.
- PRG[4]=1 → nWRAM_CE stays high at $6000 with M2 high; nRESET pulsed mid-sequence → registers return to reset values.
